// File: rtl/encoder_if.sv
// Valid/ready word handshake plus LED line and status for the optical link encoder.
`ifndef FRAME_SIZE
`define FRAME_SIZE 8
`endif

interface encoder_if #(
    parameter int W = `FRAME_SIZE
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    logic         signal;
    logic         busy;
    logic         done;

    modport master (
        output data, valid,
        input  ready, signal, busy, done
    );

    modport slave (
        input  data, valid,
        output ready, signal, busy, done
    );
endinterface

// File: rtl/encoder.sv
// Pulse-position encoder: start pulse, then one pulse per bit, LSB first.
// A bit's value is the length of the dark gap before its pulse.
`ifndef FRAME_SIZE
`define FRAME_SIZE 8
`endif
`ifndef INTERVAL_LOW
`define INTERVAL_LOW 4
`endif
`ifndef INTERVAL_HIGH
`define INTERVAL_HIGH 8
`endif

module encoder #(
    parameter int FRAME_SIZE    = `FRAME_SIZE,
    parameter int INTERVAL_LOW  = `INTERVAL_LOW,
    parameter int INTERVAL_HIGH = `INTERVAL_HIGH,
    parameter int GUARD         = 16
) (
    input  logic      clock,
    input  logic      reset,
    encoder_if.slave  bus
);
    localparam int CMAX = (INTERVAL_HIGH > GUARD) ? INTERVAL_HIGH : GUARD;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(FRAME_SIZE) + 1;

    localparam logic [CW-1:0] C_LO   = CW'(INTERVAL_LOW);
    localparam logic [CW-1:0] C_HI   = CW'(INTERVAL_HIGH);
    localparam logic [CW-1:0] C_GD   = CW'(GUARD);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [IW-1:0] I_LAST = IW'(FRAME_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GAP,
        S_PULSE,
        S_GUARD
    } state_t;

    state_t                state_q, state_d;
    logic [FRAME_SIZE-1:0] shift_q, shift_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  signal_q, signal_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.valid && ready_q) begin
                    shift_d = bus.data;
                    idx_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = shift_q[0] ? C_HI : C_LO;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q == C_ONE) begin
                    state_d = S_PULSE;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            S_PULSE: begin
                if (idx_q == I_LAST) begin
                    cnt_d   = C_GD;
                    state_d = S_GUARD;
                end else begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IW'(1);
                    cnt_d   = shift_d[0] ? C_HI : C_LO;
                    state_d = S_GAP;
                end
            end
            S_GUARD: begin
                if (cnt_q == C_ONE) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        signal_d = (state_d == S_START) || (state_d == S_PULSE);
        done_d   = (state_d == S_PULSE) && (idx_d == I_LAST);
        ready_d  = (state_d == S_IDLE);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            signal_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            signal_q <= signal_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.signal = signal_q;
    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_encoder.sv
// Directed and random bench for encoder; a line monitor decodes pulses
// back into words and a scoreboard matches them against sent words.
module tb_encoder;
    localparam int FS = 8;
    localparam int IL = 4;
    localparam int IH = 8;
    localparam int GD = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    encoder_if #(.W(FS)) u_if ();

    encoder #(
        .FRAME_SIZE(FS),
        .INTERVAL_LOW(IL),
        .INTERVAL_HIGH(IH),
        .GUARD(GD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(u_if)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic [FS-1:0] exp_q[$];
    logic [FS-1:0] got_q[$];
    int            gaps[$];
    int            starts[$];
    int            last_len = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line monitor: decodes the pulse train independently of the DUT.
    logic          m_in = 1'b0;
    logic          m_prev = 1'b0;
    int            m_gap = 0;
    int            m_nbits = 0;
    int            m_start = 0;
    logic [FS-1:0] m_word = '0;

    always @(negedge clock) begin
        if (reset) begin
            m_in = 1'b0;
            m_prev = 1'b0;
            m_gap = 0;
            m_nbits = 0;
        end else begin
            if (u_if.signal) chk("adjacent_pulse", {31'd0, m_prev}, 0);
            if (u_if.signal || u_if.done)
                chk("done_align", {31'd0, u_if.done},
                    {31'd0, u_if.signal && m_in && (m_nbits == FS - 1)});
            if (u_if.signal) begin
                if (!m_in) begin
                    m_in = 1'b1;
                    m_nbits = 0;
                    m_word = '0;
                    m_start = cyc;
                    starts.push_back(cyc);
                end else begin
                    gaps.push_back(m_gap);
                    chk("gap_legal", {31'd0, (m_gap == IL) || (m_gap == IH)}, 1);
                    m_word[m_nbits] = (m_gap == IH);
                    m_nbits++;
                    if (m_nbits == FS) begin
                        got_q.push_back(m_word);
                        last_len = cyc - m_start + 1;
                        m_in = 1'b0;
                    end
                end
                m_gap = 0;
            end else begin
                m_gap++;
            end
            m_prev = u_if.signal;
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!u_if.ready && n < 300) begin
            step();
            n++;
        end
        if (!u_if.ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [FS-1:0] w);
        u_if.valid = 1'b1;
        u_if.data  = w;
        exp_q.push_back(w);
        wait_ready();
        @(posedge clock);
        #1;
        u_if.valid = 1'b0;
        u_if.data  = FS'($urandom);
    endtask

    function automatic int frame_len(input logic [FS-1:0] w);
        int ones = $countones(w);
        return 1 + FS + ones * IH + (FS - ones) * IL;
    endfunction

    task automatic finish_frame();
        int n = 0;
        logic [FS-1:0] w, e;
        while (got_q.size() == 0 && n < 300) begin
            step();
            u_if.data = FS'($urandom);
            n++;
        end
        if (got_q.size() == 0) begin
            chk("frame_timeout", 0, 1);
            return;
        end
        w = got_q.pop_front();
        e = exp_q.pop_front();
        chk("word", {24'd0, w}, {24'd0, e});
        chk("frame_len", last_len, frame_len(e));
        n = 0;
        while (!u_if.ready && n < 100) begin
            step();
            n++;
        end
        chk("guard_len", n, GD + 1);
    endtask

    initial begin
        int n;
        int rdy_cyc;
        logic [FS-1:0] w, e;
        logic [FS-1:0] pat;

        u_if.valid = 1'b0;
        u_if.data  = '0;
        reset = 1'b1;
        repeat (3) step();
        chk("rst_outputs",
            {28'd0, u_if.signal, u_if.ready, u_if.busy, u_if.done}, 4'b0100);
        reset = 1'b0;

        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle",
                {28'd0, u_if.signal, u_if.ready, u_if.busy, u_if.done}, 4'b0100);
        end

        // A5: gaps 8,4,8,4,4,8,4,8
        gaps.delete();
        send(8'hA5);
        finish_frame();
        chk("a5_len", last_len, 57);
        pat = 8'hA5;
        for (int i = 0; i < FS; i++)
            chk("a5_gap", (gaps.size() > i) ? gaps[i] : -1, pat[i] ? IH : IL);

        // 00 then FF back-to-back, valid held, data toggling mid-frame
        gaps.delete();
        starts.delete();
        u_if.valid = 1'b1;
        u_if.data  = 8'h00;
        exp_q.push_back(8'h00);
        wait_ready();
        @(posedge clock);
        #1;
        rdy_cyc = -1;
        for (int k = 0; k < 300; k++) begin
            step();
            if (u_if.ready) begin
                rdy_cyc = cyc;
                break;
            end
            chk("no_accept_busy", {30'd0, u_if.ready, u_if.busy}, 2'b01);
            u_if.data = FS'($urandom);
        end
        chk("b2b_ready_seen", {31'd0, rdy_cyc >= 0}, 1);
        u_if.data = 8'hFF;
        exp_q.push_back(8'hFF);
        @(posedge clock);
        #1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("held_valid_ready", {31'd0, u_if.ready}, 0);
            u_if.data = FS'($urandom);
        end
        u_if.valid = 1'b0;
        n = 0;
        while (got_q.size() < 2 && n < 400) begin
            step();
            u_if.data = FS'($urandom);
            n++;
        end
        chk("b2b_frames", got_q.size(), 2);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            w = got_q.pop_front();
            e = exp_q.pop_front();
            chk("b2b_word", {24'd0, w}, {24'd0, e});
        end
        for (int i = 0; i < 2 * FS; i++)
            chk("b2b_gap", (gaps.size() > i) ? gaps[i] : -1, (i < FS) ? IL : IH);
        chk("b2b_start", (starts.size() > 1) ? starts[1] : -1, rdy_cyc + 1);
        chk("b2b_space", (starts.size() > 1) ? starts[1] - starts[0] : -1,
            frame_len(8'h00) + GD + 1);
        wait_ready();

        // Reset during the gap of bit 3 of 5A
        send(8'h5A);
        n = 0;
        while (!(m_nbits == 3 && m_in && !u_if.signal) && n < 200) begin
            step();
            n++;
        end
        chk("reach_bit3", {31'd0, m_nbits == 3}, 1);
        step();
        step();
        reset = 1'b1;
        #1;
        chk("rst_async",
            {28'd0, u_if.signal, u_if.ready, u_if.busy, u_if.done}, 4'b0100);
        repeat (3) step();
        chk("rst_hold",
            {28'd0, u_if.signal, u_if.ready, u_if.busy, u_if.done}, 4'b0100);
        reset = 1'b0;
        chk("rst_no_frame", got_q.size(), 0);
        void'(exp_q.pop_front());
        repeat (2) step();
        send(8'h3C);
        finish_frame();

        // Random words
        for (int i = 0; i < 200; i++) begin
            send(FS'($urandom_range(0, 255)));
            finish_frame();
        end

        chk("scoreboard_empty", exp_q.size() + got_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/encoder.md
# encoder

Transmit-side physical encoder for the optical link. It accepts one `FRAME_SIZE`-bit word over a valid/ready handshake and drives the LED modulator line. The word is sent as a train of single-cycle light pulses: one start pulse, then one pulse per data bit, LSB first. Each bit's value is carried by the number of dark cycles before its pulse. It sits directly upstream of the optical path whose receive end is `decoder`, and its timing parameters match that block's so frames round-trip unchanged.

## Interface
- `FRAME_SIZE`, default `` `FRAME_SIZE `` (8): data word width; the number of data pulses per frame.
- `INTERVAL_LOW`, default `` `INTERVAL_LOW `` (4): number of dark cycles before a pulse that encodes 0. Must be ≥ 1.
- `INTERVAL_HIGH`, default `` `INTERVAL_HIGH `` (8): number of dark cycles before a pulse that encodes 1. Must be > `INTERVAL_LOW`.
- `GUARD`, default 16: number of dark cycles after the last pulse of a frame. Must be ≥ `INTERVAL_HIGH`+2.
- `clock` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `data` in `FRAME_SIZE`: word to send; sampled only on an accept edge.
- `valid` in 1: `data` is presented for transmission.
- `ready` out 1: the encoder can accept a word.
- `signal` out 1: LED drive; 1 means light on.
- `busy` out 1: a frame is in progress, including the guard period.
- `done` out 1: single-cycle strobe raised when the last data pulse is emitted.

## Operation
- All outputs are registered; there is no combinational path from any input to any output.
- Reset values: `signal`=0, `ready`=1, `busy`=0, `done`=0. State goes to IDLE; the shift register and counters clear.
- State machine: IDLE → START → GAP ⇄ PULSE → GUARD → IDLE.
- **IDLE**
  - `ready`=1, `signal`=0.
  - Accept occurs on an edge where `valid`=1 and `ready`=1. On accept: latch `data` into the shift register, clear `bit_idx`, go to START, drop `ready`, set `busy`.
- **START**
  - `signal`=1 for exactly one cycle.
  - Load the gap counter with `INTERVAL_HIGH` if `shift[0]`=1, else `INTERVAL_LOW`.
  - Go to GAP.
- **GAP**
  - `signal`=0.
  - Decrement the gap counter; after exactly the loaded number of dark cycles, go to PULSE.
- **PULSE**
  - `signal`=1 for one cycle.
  - If `bit_idx`=`FRAME_SIZE`-1: raise `done` for this cycle, load the guard counter with `GUARD`, go to GUARD.
  - Otherwise: shift right, increment `bit_idx`, load the gap counter for the new `shift[0]`, go to GAP.
- **GUARD**
  - `signal`=0 for exactly `GUARD` cycles.
  - Then go to IDLE with `ready`=1 and `busy`=0.
- Counter widths: the gap/guard counter is wide enough for max(`INTERVAL_HIGH`, `GUARD`). `bit_idx` is $clog2(`FRAME_SIZE`)+1 bits. No wrap-around is reachable.
- `valid` outside IDLE is ignored. There is no queueing; the upstream source holds `valid` until it sees `ready`.
- Changes on `data` after accept have no effect on the frame in progress.
- If reset is asserted mid-frame, `signal` drops to 0 immediately and the frame is abandoned. The receiver's timeout discards the partial frame.

## Timing
- Accept edge at cycle k: the start pulse is high during cycle k+1.
- Frame length from the start pulse to the end of the last data pulse: 1 + `FRAME_SIZE` + (number of ones)·`INTERVAL_HIGH` + (number of zeros)·`INTERVAL_LOW` cycles.
- `done` is coincident with the last pulse.
- `ready` returns to 1 in the cycle after the final GUARD cycle. Back-to-back accepts are therefore spaced by frame length + `GUARD` + 1 cycles.
- Pulse width is always 1 cycle; two adjacent high cycles never occur.

## Test plan
- Reset, then idle with `valid`=0 → `signal` stays 0, `ready`=1, `busy`=0, `done`=0 for 100 cycles.
- Send `data`=8'hA5 with default parameters → 9 pulses with dark gaps 8,4,8,4,4,8,4,8. `done` coincides with the 9th pulse, 57 cycles after the start pulse. `ready` rises after 16 guard cycles.
- Send 8'h00, then 8'hFF back-to-back with `valid` held high → gaps are all 4, then all 8. The second start pulse occurs 1 cycle after `ready` rises. `data` toggling mid-frame does not alter any gap.
- Loopback into `decoder` with random words (≥200) → the decoder's `data` equals the sent word on every `irq`, and no decoder timeout occurs.
- Assert `reset` during the gap of bit 3 of 8'h5A → `signal` is 0 asynchronously and all outputs return to their reset values. The next word, 8'h3C, is sent intact and decoded correctly.
- Present `valid`=1 while `busy`=1 → no accept occurs and `ready` stays 0. The word is taken on the first edge with `ready`=1.
